round_robin_select: RTL and testbench
=====================================

// Module: round_robin_select
//
// PURPOSE
// - Registered round-robin arbiter for up to WIDTH requesters.
// - Produces a binary grant index (sel) plus a valid strobe (enable).
// - sel/enable drive a Decoder of the same WIDTH directly; the Decoder turns them into a one-hot grant vector.
// - Grants are sticky while the owner holds its request, with an optional hold limit so no requester can starve the others.
//
// PARAMETERS
// - WIDTH      16               number of requesters; any value >= 2, need not be a power of two
// - MAX_HOLD   8                max consecutive grant cycles while others wait; 0 = unlimited
// - ADDR_SIZE  $clog2(WIDTH)    derived; width of sel; do not override
//
// PORTS
// - clk        input   1          single clock; all state changes on posedge clk
// - reset      input   1          synchronous, active-high reset
// - req        input   WIDTH      request vector; req[i]=1 means requester i wants the resource
// - sel        output  ADDR_SIZE  index of current owner; always < WIDTH
// - enable     output  1          1 = sel is a valid grant (feeds Decoder enable)
// - grant_new  output  1          one-cycle pulse in the first cycle of every new grant
//
// BEHAVIOUR
// Registers and reset
// - All outputs are registered; there is no combinational path from req to any output.
// - reset=1 at a posedge sets: sel=0, enable=0, grant_new=0, ptr=0, hold_cnt=0, state=IDLE.
// - Reset applied mid-grant drops enable on that same edge. No partial state survives.
//
// Priority pointer
// - ptr = the highest-priority index.
// - The search order is ptr, ptr+1, ..., WIDTH-1, 0, ..., ptr-1.
//
// States
// - IDLE:
//   - If |req, winner = first set bit in search order.
//   - Next edge: state=GRANT, sel=winner, enable=1, grant_new=1, hold_cnt=1.
//   - Latency from req rising to enable=1 is exactly 1 cycle.
// - GRANT: the grant is released at a posedge when either condition holds:
//   - (a) req[sel]==0 (owner done), or
//   - (b) MAX_HOLD!=0 && hold_cnt==MAX_HOLD && (req & ~onehot(sel))!=0 (timeout with a waiter).
// - On release:
//   - ptr <= (sel==WIDTH-1) ? 0 : sel+1. Wrap is explicit, not a mod-2^ADDR_SIZE wrap.
//   - Search the candidates req & ~onehot(sel) in the new ptr order.
//   - If a candidate exists, grant back-to-back with no idle bubble: sel=winner, enable=1, grant_new=1, hold_cnt=1, stay in GRANT.
//   - Otherwise state=IDLE, enable=0, grant_new=0, sel keeps its last value.
// - Not released:
//   - enable=1 and grant_new=0.
//   - hold_cnt increments, saturating at MAX_HOLD; it saturates at 1 when MAX_HOLD==0.
//   - Timeout with no other requester keeps the grant; hold_cnt stays saturated.
//
// Boundary cases
// - Simultaneous release and a new request from the same index: that index is excluded this cycle. It can win at the earliest on the following arbitration.
// - Requests that arrive or drop during GRANT for non-owners are only sampled at release.
// - sel bits outside [0, WIDTH-1] never occur. This holds for non-power-of-two WIDTH, e.g. WIDTH=5 gives sel in 0..4.
//
// STRUCTURE
// - Shared package ArbiterPkg holds:
//   - typedef enum logic {IDLE, GRANT} arb_state_t;
//   - function next_index(idx, width) for the wrap-aware increment.
// - One sub-module rr_pick: purely combinational rotating find-first.
//   - Inputs: req vector, ptr.
//   - Outputs: found, idx.
//   - Implementation: double-width mask scan, or masked/unmasked priority encode.
// - This module holds only the state, ptr, hold_cnt, and output registers. Target is about 150-250 lines total.
// - Reusing rr_pick is intended for future arbiter variants.
//
// TESTING
// Bench instantiates round_robin_select -> Decoder (same WIDTH).
// It checks onehot(Decoder.out) == enable ? 1<<sel : 0 every cycle.
// 1. Reset, then WIDTH=16, req=16'h0001 at cycle 0 -> cycle 1: enable=1, sel=0, grant_new=1. Drop req -> next cycle enable=0, sel=0.
// 2. req=16'h8001 held, MAX_HOLD=8 -> sel=0 for 8 cycles, then sel=15 for 8 cycles, then sel=0. grant_new pulses at each switch; enable never drops.
// 3. ptr=15 after a grant to 14: req=16'h8000 only -> sel=15. After release, req=16'h0003 -> sel=0, then 1 (wrap check).
// 4. Owner idx 3 drops req in the same cycle idx 5 raises its req -> next cycle sel=5, grant_new=1, no enable gap.
// 5. reset asserted mid-GRANT (sel=7) -> next edge enable=0, sel=0, grant_new=0. With req=16'h0080 still high, re-grant 1 cycle after reset deasserts.
// 6. WIDTH=5, MAX_HOLD=0, req=5'b11111, each owner drops req after 2 cycles -> grants go 0,1,2,3,4,0. sel never exceeds 4. No timeout preemption.

Source files
------------

// File: rtl/ArbiterPkg.sv
// Shared arbiter types and helpers used by round_robin_select and future variants.
package ArbiterPkg;

   typedef enum logic {IDLE, GRANT} arb_state_t;

   // Wrap-aware increment; wraps at width, not at a power of two.
   function automatic int next_index(input int idx, input int width);
      return (idx == width - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/Decoder.sv
// Binary-to-one-hot decoder driven by the arbiter's sel/enable pair.
module Decoder #(
   parameter int WIDTH     = 16,
   parameter int ADDR_SIZE = $clog2(WIDTH)
) (
   input  logic [ADDR_SIZE-1:0] sel,
   input  logic                 enable,
   output logic [WIDTH-1:0]     out
);

   assign out = enable ? (WIDTH'(1) << sel) : '0;

endmodule

// File: rtl/rr_pick.sv
// Combinational rotating find-first: first set bit of req in the order ptr, ptr+1, ..., ptr-1.
module rr_pick #(
   parameter int WIDTH     = 16,
   parameter int ADDR_SIZE = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0]     req,
   input  logic [ADDR_SIZE-1:0] ptr,
   output logic                 found,
   output logic [ADDR_SIZE-1:0] idx
);

   int                   pos;
   logic [ADDR_SIZE-1:0] cand;

   // Scan from the farthest position towards ptr so the nearest hit is written last.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = 0;
      cand  = '0;
      for (int k = WIDTH - 1; k >= 0; k--) begin
         pos = int'(ptr) + k;
         if (pos >= WIDTH) pos = pos - WIDTH;
         cand = ADDR_SIZE'(pos);
         if (req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/round_robin_select.sv
// Registered round-robin arbiter with sticky grants and an optional hold limit.
module round_robin_select
   import ArbiterPkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int MAX_HOLD  = 8,
   parameter int ADDR_SIZE = $clog2(WIDTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     req,
   output logic [ADDR_SIZE-1:0] sel,
   output logic                 enable,
   output logic                 grant_new
);

   // With no hold limit the counter simply saturates at 1.
   localparam int HOLD_LIMIT = (MAX_HOLD == 0) ? 1 : MAX_HOLD;
   localparam int HOLD_W     = $clog2(HOLD_LIMIT + 1);

   arb_state_t           state_reg, state_next;
   logic [ADDR_SIZE-1:0] sel_reg, sel_next;
   logic                 enable_reg, enable_next;
   logic                 grant_new_reg, grant_new_next;
   logic [ADDR_SIZE-1:0] ptr_reg, ptr_next;
   logic [HOLD_W-1:0]    hold_cnt_reg, hold_cnt_next;

   logic [WIDTH-1:0]     owner_mask;
   logic [WIDTH-1:0]     waiters;
   logic                 hold_done;
   logic                 release_now;
   logic [WIDTH-1:0]     pick_req;
   logic [ADDR_SIZE-1:0] pick_ptr;
   logic                 pick_found;
   logic [ADDR_SIZE-1:0] pick_idx;

   always_comb begin
      owner_mask  = WIDTH'(1) << sel_reg;
      waiters     = req & ~owner_mask;
      hold_done   = (MAX_HOLD != 0) && (int'(hold_cnt_reg) == MAX_HOLD);
      release_now = !req[sel_reg] || (hold_done && (|waiters));
      // IDLE searches all requests from ptr; a release excludes the outgoing owner.
      pick_req    = (state_reg == IDLE) ? req : waiters;
      pick_ptr    = (state_reg == IDLE) ? ptr_reg
                                        : ADDR_SIZE'(next_index(int'(sel_reg), WIDTH));
   end

   rr_pick #(
      .WIDTH     (WIDTH),
      .ADDR_SIZE (ADDR_SIZE)
   ) u_pick (
      .req   (pick_req),
      .ptr   (pick_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      state_next     = state_reg;
      sel_next       = sel_reg;
      enable_next    = 1'b0;
      grant_new_next = 1'b0;
      ptr_next       = ptr_reg;
      hold_cnt_next  = hold_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (pick_found) begin
               state_next     = GRANT;
               sel_next       = pick_idx;
               enable_next    = 1'b1;
               grant_new_next = 1'b1;
               hold_cnt_next  = HOLD_W'(1);
            end
         end
         GRANT: begin
            if (release_now) begin
               ptr_next = pick_ptr;
               if (pick_found) begin
                  sel_next       = pick_idx;
                  enable_next    = 1'b1;
                  grant_new_next = 1'b1;
                  hold_cnt_next  = HOLD_W'(1);
               end else begin
                  state_next = IDLE;
               end
            end else begin
               enable_next = 1'b1;
               if (int'(hold_cnt_reg) < HOLD_LIMIT) hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         sel_reg       <= '0;
         enable_reg    <= 1'b0;
         grant_new_reg <= 1'b0;
         ptr_reg       <= '0;
         hold_cnt_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         sel_reg       <= sel_next;
         enable_reg    <= enable_next;
         grant_new_reg <= grant_new_next;
         ptr_reg       <= ptr_next;
         hold_cnt_reg  <= hold_cnt_next;
      end
   end

   assign sel       = sel_reg;
   assign enable    = enable_reg;
   assign grant_new = grant_new_reg;

endmodule

// File: tb/tb_round_robin_select.sv
// Directed bench: a 16-wide (hold limit 8) and a 5-wide (unlimited hold) arbiter, each feeding a Decoder.
module tb_round_robin_select;

   logic        clk = 1'b0;
   logic        reset16 = 1'b1;
   logic [15:0] req16 = '0;
   logic [3:0]  sel16;
   logic        en16, gn16;
   logic [15:0] dec16;

   logic        reset5 = 1'b1;
   logic [4:0]  req5 = '0;
   logic [2:0]  sel5;
   logic        en5, gn5;
   logic [4:0]  dec5;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   round_robin_select #(.WIDTH(16), .MAX_HOLD(8)) u_dut16 (
      .clk(clk), .reset(reset16), .req(req16),
      .sel(sel16), .enable(en16), .grant_new(gn16));
   Decoder #(.WIDTH(16)) u_dec16 (.sel(sel16), .enable(en16), .out(dec16));

   round_robin_select #(.WIDTH(5), .MAX_HOLD(0)) u_dut5 (
      .clk(clk), .reset(reset5), .req(req5),
      .sel(sel5), .enable(en5), .grant_new(gn5));
   Decoder #(.WIDTH(5)) u_dec5 (.sel(sel5), .enable(en5), .out(dec5));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check16(input string tag, input int esel, input logic een, input logic egn);
      logic [15:0] edec;
      edec = een ? (16'd1 << esel) : 16'd0;
      check({tag, ".sel"},    32'(sel16), 32'(esel));
      check({tag, ".enable"}, 32'(en16),  32'(een));
      check({tag, ".gnew"},   32'(gn16),  32'(egn));
      check({tag, ".dec"},    32'(dec16), 32'(edec));
      $display("[TB] %s req=%04h sel=%0d en=%0b gn=%0b", tag, req16, sel16, en16, gn16);
   endtask

   task automatic check5(input string tag, input int esel, input logic een, input logic egn);
      logic [4:0] edec;
      edec = een ? (5'd1 << esel) : 5'd0;
      check({tag, ".sel"},    32'(sel5), 32'(esel));
      check({tag, ".enable"}, 32'(en5),  32'(een));
      check({tag, ".gnew"},   32'(gn5),  32'(egn));
      check({tag, ".dec"},    32'(dec5), 32'(edec));
      check({tag, ".range"},  32'(sel5 <= 3'd4), 32'd1);
      $display("[TB] %s req=%05b sel=%0d en=%0b gn=%0b", tag, req5, sel5, en5, gn5);
   endtask

   initial begin
      int exp_sel;

      // 1: reset state, single request, release to IDLE
      step(); step();
      check16("t1_reset", 0, 1'b0, 1'b0);
      reset16 = 1'b0;
      req16 = 16'h0001;
      step();
      check16("t1_grant", 0, 1'b1, 1'b1);
      req16 = 16'h0000;
      step();
      check16("t1_drop", 0, 1'b0, 1'b0);

      // 2: two contenders alternate on the hold limit (reset first so ptr=0)
      reset16 = 1'b1;
      step();
      reset16 = 1'b0;
      req16 = 16'h8001;
      for (int i = 0; i < 24; i++) begin
         step();
         exp_sel = (i < 8) ? 0 : (i < 16) ? 15 : 0;
         check16($sformatf("t2_c%0d", i), exp_sel, 1'b1, (i % 8) == 0);
      end
      req16 = 16'h0000;
      step();
      check16("t2_idle", 0, 1'b0, 1'b0);

      // 2b: timeout with no waiter keeps the grant (ptr now 1, so 1 wins)
      req16 = 16'h0002;
      step();
      check16("t2b_grant", 1, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) begin
         step();
         check16($sformatf("t2b_hold%0d", i), 1, 1'b1, 1'b0);
      end
      req16 = 16'h0000;
      step();
      check16("t2b_idle", 1, 1'b0, 1'b0);

      // 3: grant 14, then 15, then wrap to 0 and 1
      req16 = 16'h4000;
      step();
      check16("t3_g14", 14, 1'b1, 1'b1);
      req16 = 16'h8000;
      step();
      check16("t3_g15", 15, 1'b1, 1'b1);
      req16 = 16'h0003;
      step();
      check16("t3_g0", 0, 1'b1, 1'b1);
      req16 = 16'h0002;
      step();
      check16("t3_g1", 1, 1'b1, 1'b1);
      req16 = 16'h0000;
      step();
      check16("t3_idle", 1, 1'b0, 1'b0);

      // 4: owner 3 drops as 5 raises -> back-to-back grant to 5
      req16 = 16'h0008;
      step();
      check16("t4_g3", 3, 1'b1, 1'b1);
      step();
      check16("t4_h3", 3, 1'b1, 1'b0);
      req16 = 16'h0020;
      step();
      check16("t4_g5", 5, 1'b1, 1'b1);
      req16 = 16'h0000;
      step();
      check16("t4_idle", 5, 1'b0, 1'b0);

      // 5: reset mid-grant, then re-grant one cycle after release of reset
      req16 = 16'h0080;
      step();
      check16("t5_g7", 7, 1'b1, 1'b1);
      reset16 = 1'b1;
      step();
      check16("t5_rst", 0, 1'b0, 1'b0);
      reset16 = 1'b0;
      step();
      check16("t5_regrant", 7, 1'b1, 1'b1);
      req16 = 16'h0000;

      // 6: WIDTH=5, unlimited hold, each owner leaves after 2 cycles
      step();
      check5("t6_reset", 0, 1'b0, 1'b0);
      reset5 = 1'b0;
      req5 = 5'b11111;
      step();
      check5("t6_g0", 0, 1'b1, 1'b1);
      for (int g = 0; g < 5; g++) begin
         step();
         check5($sformatf("t6_hold%0d", g), g, 1'b1, 1'b0);
         req5 = 5'b11111 & ~(5'd1 << g);
         step();
         check5($sformatf("t6_next%0d", g), (g + 1) % 5, 1'b1, 1'b1);
         req5 = 5'b11111;
      end
      for (int i = 0; i < 10; i++) begin
         step();
         check5($sformatf("t6_nopre%0d", i), 0, 1'b1, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
